// File: rtl/sunrise_adjust_input.sv
// Button front end: sync, debounce, decode and one strobe per press (optional hold-to-repeat under SUNRISE_ADJUST_REPEAT_EN).
// Pulse registered DEBOUNCE_CYCLES+2 edges after a clean press; one-cycle strobe, no backpressure.
module sunrise_adjust_input #(
    parameter int CNT_W           = 25,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       adjust_en,
    input  logic       btn_min_up,
    input  logic       btn_min_down,
    input  logic       btn_hr_up,
    input  logic       btn_hr_down,
    output logic [2:0] sunrise_time_adjust,
    output logic       adjust_busy
);

`ifdef SUNRISE_ADJUST_REPEAT_EN
    typedef enum logic [1:0] {IDLE, HOLD, REPEAT, LOCKOUT} state_t;
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`else
    typedef enum logic [1:0] {IDLE, HOLD, LOCKOUT} state_t;
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       db_q, db_d;
    logic [CNT_W-1:0] db_cnt_q [4];
    logic [CNT_W-1:0] db_cnt_d [4];
    logic [2:0]       code;
    logic [2:0]       lat_code_q, lat_code_d;
    logic [2:0]       adj_q, adj_d;
    state_t           state_q, state_d;

    // Bit order matches the adjust code order: code = bit index + 1.
    assign btn_raw = {btn_hr_down, btn_hr_up, btn_min_down, btn_min_up};

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (db_q)
            4'b0001: code = 3'd1;
            4'b0010: code = 3'd2;
            4'b0100: code = 3'd3;
            4'b1000: code = 3'd4;
            default: code = 3'd0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        lat_code_d = lat_code_q;
        adj_d      = 3'd0;
`ifdef SUNRISE_ADJUST_REPEAT_EN
        rpt_cnt_d  = rpt_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (db_q != 4'b0000) begin
                    if (adjust_en && (code != 3'd0)) begin
                        adj_d      = code;
                        lat_code_d = code;
                        state_d    = HOLD;
`ifdef SUNRISE_ADJUST_REPEAT_EN
                        rpt_cnt_d  = '0;
`endif
                    end else begin
                        state_d = LOCKOUT;
                    end
                end
            end
            LOCKOUT: begin
                if (db_q == 4'b0000) state_d = IDLE;
            end
            default: begin
                // A matching code implies the same single button is still the only one held.
                if (db_q == 4'b0000) begin
                    state_d = IDLE;
                end else if ((code != lat_code_q) || !adjust_en) begin
                    state_d = LOCKOUT;
                end
`ifdef SUNRISE_ADJUST_REPEAT_EN
                else if ((state_q == HOLD) ? (rpt_cnt_q == CNT_W'(REPEAT_DELAY - 1))
                                           : (rpt_cnt_q == CNT_W'(REPEAT_PERIOD - 1))) begin
                    adj_d     = lat_code_q;
                    rpt_cnt_d = '0;
                    state_d   = REPEAT;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_q       <= '0;
            lat_code_q <= '0;
            adj_q      <= '0;
            state_q    <= IDLE;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
`ifdef SUNRISE_ADJUST_REPEAT_EN
            rpt_cnt_q  <= '0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            db_q       <= db_d;
            lat_code_q <= lat_code_d;
            adj_q      <= adj_d;
            state_q    <= state_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
`ifdef SUNRISE_ADJUST_REPEAT_EN
            rpt_cnt_q  <= rpt_cnt_d;
`endif
        end
    end

    assign sunrise_time_adjust = adj_q;
    assign adjust_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sunrise_adjust_input.sv
// Bench for sunrise_adjust_input: directed scenarios plus random presses against an edge-indexed reference model.
`timescale 1ns/1ps
module tb_sunrise_adjust_input;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;
    localparam int W  = 8;
`ifdef SUNRISE_ADJUST_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_HELD = 1;
    localparam int M_LOCK = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       adjust_en;
    logic       btn_min_up, btn_min_down, btn_hr_up, btn_hr_down;
    logic [2:0] sunrise_time_adjust;
    logic       adjust_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sunrise_adjust_input #(
        .CNT_W(W), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .adjust_en(adjust_en),
        .btn_min_up(btn_min_up), .btn_min_down(btn_min_down),
        .btn_hr_up(btn_hr_up), .btn_hr_down(btn_hr_down),
        .sunrise_time_adjust(sunrise_time_adjust), .adjust_busy(adjust_busy)
    );

    // Reference model: raw -> two-sample delay -> streak-of-D acceptance -> press tracker with absolute repeat deadlines.
    logic [3:0] m_s1, m_s2, m_db, m_lat;
    int         m_streak [4];
    int         m_mode, m_next, m_edge;
    logic [2:0] m_out;
    logic       m_busy;

    function automatic logic [2:0] code_of(input logic [3:0] v);
        logic [2:0] c;
        c = 3'd0;
        if ($countones(v) == 1)
            for (int i = 0; i < 4; i++) if (v[i]) c = 3'(i + 1);
        return c;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0; m_lat = '0;
        for (int i = 0; i < 4; i++) m_streak[i] = 0;
        m_mode = M_IDLE; m_next = 0; m_edge = 0; m_out = '0; m_busy = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] raw, input logic en);
        logic [3:0] db_old;
        int         ones;
        db_old = m_db;
        ones   = $countones(db_old);
        m_out  = 3'd0;
        if (m_mode == M_IDLE) begin
            if (ones > 0) begin
                if (en && ones == 1) begin
                    m_out = code_of(db_old); m_lat = db_old; m_next = m_edge + RD; m_mode = M_HELD;
                end else begin
                    m_mode = M_LOCK;
                end
            end
        end else if (m_mode == M_HELD) begin
            if (ones == 0) m_mode = M_IDLE;
            else if (db_old != m_lat || !en) m_mode = M_LOCK;
            else if (REP_EN && m_edge == m_next) begin
                m_out = code_of(m_lat); m_next = m_edge + RP;
            end
        end else if (ones == 0) begin
            m_mode = M_IDLE;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_streak[i]++;
                if (m_streak[i] == D) begin m_db[i] = ~m_db[i]; m_streak[i] = 0; end
            end else begin
                m_streak[i] = 0;
            end
        end
        m_s2 = m_s1; m_s1 = raw; m_edge++;
        m_busy = (m_mode != M_IDLE);
    endtask

    task automatic step(input logic [3:0] raw, input logic en);
        {btn_hr_down, btn_hr_up, btn_min_down, btn_min_up} = raw;
        adjust_en = en;
        @(posedge clk);
        if (rst_n) model_edge(raw, en);
        #1;
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) step(4'b0000, 1'b1);
    endtask

    task automatic test_reset();
        int first_idx; logic [2:0] first_code;
        rst_n = 1'b0; model_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b0100, 1'b1);
            total++;
            if ({sunrise_time_adjust, adjust_busy} !== 4'b0000) begin
                bad++; $display("FAIL reset_hold cyc=%0d got adj=%0d busy=%0b want adj=0 busy=0", i, sunrise_time_adjust, adjust_busy);
            end
        end
        rst_n = 1'b1;
        first_idx = -1; first_code = 3'd0;
        for (int i = 0; i < 12; i++) begin
            step(4'b0100, 1'b1);
            total++;
            if ({sunrise_time_adjust, adjust_busy} !== {m_out, m_busy}) begin
                bad++; $display("FAIL reset_release cyc=%0d got adj=%0d busy=%0b want adj=%0d busy=%0b", i, sunrise_time_adjust, adjust_busy, m_out, m_busy);
            end
            if (sunrise_time_adjust != 3'd0 && first_idx < 0) begin first_idx = i; first_code = sunrise_time_adjust; end
        end
        total++;
        if (first_idx !== 6 || first_code !== 3'd3) begin
            bad++; $display("FAIL reset_first_pulse got edge=%0d code=%0d want edge=6 code=3", first_idx, first_code);
        end
        settle();
    endtask

    task automatic test_single_press();
        int pulses, first_idx; logic [2:0] first_code;
        pulses = 0; first_idx = -1; first_code = 3'd0;
        for (int i = 0; i < 20; i++) begin
            step((i < 8) ? 4'b0001 : 4'b0000, 1'b1);
            total++;
            if ({sunrise_time_adjust, adjust_busy} !== {m_out, m_busy}) begin
                bad++; $display("FAIL single_press cyc=%0d got adj=%0d busy=%0b want adj=%0d busy=%0b", i, sunrise_time_adjust, adjust_busy, m_out, m_busy);
            end
            if (sunrise_time_adjust != 3'd0) begin
                pulses++;
                if (first_idx < 0) begin first_idx = i; first_code = sunrise_time_adjust; end
            end
        end
        total++;
        if (pulses !== 1 || first_idx !== 6 || first_code !== 3'd1 || adjust_busy !== 1'b0) begin
            bad++; $display("FAIL single_press_summary got pulses=%0d edge=%0d code=%0d busy=%0b want 1/6/1/0", pulses, first_idx, first_code, adjust_busy);
        end
    endtask

    task automatic test_bounce();
        int pulses, busy_seen;
        pulses = 0; busy_seen = 0;
        for (int i = 0; i < 22; i++) begin
            step((i < 12 && ((i / 2) % 2 == 0)) ? 4'b1000 : 4'b0000, 1'b1);
            total++;
            if ({sunrise_time_adjust, adjust_busy} !== {m_out, m_busy}) begin
                bad++; $display("FAIL bounce cyc=%0d got adj=%0d busy=%0b want adj=%0d busy=%0b", i, sunrise_time_adjust, adjust_busy, m_out, m_busy);
            end
            if (sunrise_time_adjust != 3'd0) pulses++;
            if (adjust_busy) busy_seen++;
        end
        total++;
        if (pulses !== 0 || busy_seen !== 0) begin
            bad++; $display("FAIL bounce_summary got pulses=%0d busy_cycles=%0d want 0/0", pulses, busy_seen);
        end
    endtask

    task automatic test_repeat();
        int got[$]; int want[$]; int b2b; logic [2:0] prev;
        b2b = 0; prev = 3'd0;
        want.push_back(6);
`ifdef SUNRISE_ADJUST_REPEAT_EN
        for (int t = 6 + RD; t <= 36 + 1 + D; t += RP) want.push_back(t);
`endif
        for (int i = 0; i < 50; i++) begin
            step((i < 36) ? 4'b0010 : 4'b0000, 1'b1);
            total++;
            if ({sunrise_time_adjust, adjust_busy} !== {m_out, m_busy}) begin
                bad++; $display("FAIL repeat cyc=%0d got adj=%0d busy=%0b want adj=%0d busy=%0b", i, sunrise_time_adjust, adjust_busy, m_out, m_busy);
            end
            if (sunrise_time_adjust != 3'd0) begin
                got.push_back(i);
                if (sunrise_time_adjust != 3'd2) b2b++;
            end
            if (sunrise_time_adjust != 3'd0 && prev != 3'd0) b2b++;
            prev = sunrise_time_adjust;
        end
        total++;
        if (got.size() !== want.size() || b2b !== 0) begin
            bad++; $display("FAIL repeat_count got pulses=%0d bad_codes_or_b2b=%0d want pulses=%0d 0", got.size(), b2b, want.size());
        end else begin
            for (int j = 0; j < want.size(); j++) begin
                total++;
                if (got[j] !== want[j]) begin
                    bad++; $display("FAIL repeat_edge idx=%0d got edge=%0d want edge=%0d", j, got[j], want[j]);
                end
            end
        end
    endtask

    task automatic test_multi_press();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            step((i < 8) ? 4'b0101 : 4'b0001, 1'b1);
            total++;
            if ({sunrise_time_adjust, adjust_busy} !== {m_out, m_busy}) begin
                bad++; $display("FAIL multi cyc=%0d got adj=%0d busy=%0b want adj=%0d busy=%0b", i, sunrise_time_adjust, adjust_busy, m_out, m_busy);
            end
            if (sunrise_time_adjust != 3'd0) pulses++;
        end
        total++;
        if (pulses !== 0 || adjust_busy !== 1'b1) begin
            bad++; $display("FAIL multi_lockout got pulses=%0d busy=%0b want 0/1", pulses, adjust_busy);
        end
        settle();
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step((i < 8) ? 4'b0001 : 4'b0000, 1'b1);
            if (sunrise_time_adjust == 3'd1) pulses++;
        end
        total++;
        if (pulses !== 1) begin
            bad++; $display("FAIL multi_recover got pulses=%0d want 1", pulses);
        end
    endtask

    task automatic test_enable_low();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            step(4'b0100, 1'b0);
            if (sunrise_time_adjust != 3'd0) pulses++;
        end
        total++;
        if (pulses !== 0 || adjust_busy !== 1'b1) begin
            bad++; $display("FAIL enable_low got pulses=%0d busy=%0b want 0/1", pulses, adjust_busy);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int got[$]; int want[$];
        int hit;
        hit = REP_EN ? 16 : 6;
        for (int i = 0; i <= hit; i++) step(4'b0100, 1'b1);
        #2; rst_n = 1'b0; model_reset(); #1;
        total++;
        if ({sunrise_time_adjust, adjust_busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_mid_async got adj=%0d busy=%0b want adj=0 busy=0", sunrise_time_adjust, adjust_busy);
        end
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1);
        rst_n = 1'b1;
        want.push_back(6);
`ifdef SUNRISE_ADJUST_REPEAT_EN
        want.push_back(6 + RD);
`endif
        for (int i = 0; i < 18; i++) begin
            step(4'b0100, 1'b1);
            if (sunrise_time_adjust != 3'd0) got.push_back(i);
        end
        total++;
        if (got.size() !== want.size() || got[0] !== want[0] || got[got.size()-1] !== want[want.size()-1]) begin
            bad++; $display("FAIL reset_mid_restart got pulses=%0d first=%0d want pulses=%0d first=6", got.size(), (got.size() > 0) ? got[0] : -1, want.size());
        end
        settle();
    endtask

    task automatic test_random();
        logic [3:0] raw; logic en; int len, pick, errs;
        errs = 0;
        for (int seg = 0; seg < 120; seg++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6)      raw = 4'(1 << $urandom_range(0, 3));
            else if (pick < 8) raw = 4'b0000;
            else               raw = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 9) != 0);
            len = $urandom_range(1, 25);
            for (int i = 0; i < len; i++) begin
                step(raw, en);
                total++;
                if ({sunrise_time_adjust, adjust_busy} !== {m_out, m_busy}) begin
                    bad++; errs++;
                    if (errs < 10) $display("FAIL random seg=%0d cyc=%0d raw=%b en=%0b got adj=%0d busy=%0b want adj=%0d busy=%0b", seg, i, raw, en, sunrise_time_adjust, adjust_busy, m_out, m_busy);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; adjust_en = 1'b1;
        {btn_hr_down, btn_hr_up, btn_min_down, btn_min_up} = 4'b0000;
        model_reset();
        test_reset();
        test_single_press();
        test_bounce();
        test_repeat();
        settle();
        test_multi_press();
        test_enable_low();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
